usb_xact_sched: RTL and testbench
=================================

Name: usb_xact_sched

Overview:
Transaction scheduler in front of the USB full-speed packet driver (drv_usb). Arbitrates between a software request port and an internal periodic interrupt-endpoint poller, and expands each request into a packet sequence: token, then optional DATA0/DATA1, or bus reset. Tracks per-endpoint data toggle, enforces an inter-packet gap, and times out a driver that never completes.

Parameters:
POLL_PERIOD, 60000, clk60 cycles between poll requests (1 ms)
GAP_CYCLES, 20, idle cycles after drv_cmd_done before next drv_snd
TIMEOUT_CYCLES, 4095, max cycles waiting for drv_cmd_done per packet (reset packet exempt)

Ports:
clk60  in  1  clock
rst_n  in  1  synchronous, active-low reset
sw_req  in  1  software request, level, held until sw_ack
sw_kind  in  2  0=SETUP+DATA0, 1=OUT+DATAx, 2=IN token, 3=bus reset
sw_addr  in  7  device address
sw_ep  in  4  endpoint
sw_data  in  64  payload for kinds 0/1
sw_ack  out  1  one-cycle grant; sw_* sampled this cycle
sw_done  out  1  one-cycle pulse, software transaction complete
sw_err  out  1  one-cycle pulse, software transaction timed out
poll_en  in  1  enable periodic poll
poll_addr  in  7  poll target address
poll_ep  in  4  poll target endpoint
poll_done  out  1  one-cycle pulse, poll IN token complete
poll_overrun  out  1  one-cycle pulse, period elapsed while poll still pending
busy  out  1  high in any state except IDLE
drv_snd  out  1  one-cycle send strobe to driver
drv_pid  out  4  PID for driver
drv_addr  out  7  address for driver
drv_end_pt  out  4  endpoint for driver
drv_data  out  64  payload for driver
drv_stat  out  1  always 0
drv_dev_rst  out  1  bus reset request, valid with drv_snd
drv_cmd_done  in  1  driver packet complete pulse

Behaviour:
- Reset: all outputs 0, toggle[15:0]=0, poll counter 0, poll_pending 0, last_grant=poll, state IDLE.
- PIDs: SETUP 4'b1101, OUT 4'b0001, IN 4'b1001, DATA0 4'b0011, DATA1 4'b1011.
- Poll timer: counts while poll_en; at POLL_PERIOD-1 wraps to 0 and sets poll_pending. If already pending then, poll_overrun pulses and pending stays 1. poll_en=0 clears counter, leaves pending.
- Arbitration in IDLE only: one requester -> grant it; both -> the one not granted last (round-robin). Grant cycle: sw_ack pulse (sw) or poll_pending cleared (poll); request latched; go TOK.
- States: IDLE, TOK, TOK_WAIT, GAP, DAT, DAT_WAIT, RST, RST_WAIT, FIN.
- TOK: drv_snd=1 one cycle with token PID, addr, ep; kind 3 instead goes RST. -> TOK_WAIT.
- TOK_WAIT: on drv_cmd_done: kinds 0/1 -> GAP then DAT; kind 2 -> FIN.
- GAP: GAP_CYCLES cycles of wait, no snd.
- DAT: drv_snd with DATA0 (kind 0) or toggle[ep]?DATA1:DATA0 (kind 1), drv_data=latched payload. -> DAT_WAIT. On drv_cmd_done: kind 0 sets toggle[ep]=1; kind 1 inverts toggle[ep]; -> FIN.
- RST: drv_snd=1, drv_dev_rst=1; RST_WAIT waits drv_cmd_done with no timeout; completion clears toggle[15:0]. -> FIN.
- FIN: done pulse to owning requester (sw_done or poll_done); GAP_CYCLES wait; -> IDLE.
- Timeout: counter cleared on every drv_snd; reaching TIMEOUT_CYCLES in TOK_WAIT/DAT_WAIT -> sw_err (sw owner; poll silently dropped), toggle unchanged, -> IDLE. drv_cmd_done on the same cycle as expiry wins.
- drv_* fields registered, stable from drv_snd until the next drv_snd. drv_cmd_done outside a WAIT state is ignored.
- sw_req deasserted before sw_ack: no transaction. Reset mid-transaction: immediate return to reset values, no done/err pulse.

Test Plan:
- sw kind 0, addr 0x05, ep 0, data 0x1122334455667788; cmd_done 30 cycles after each snd -> snd PID 1101 then, >=20 cycles after done, PID 0011 with data; sw_done once; toggle[0]=1.
- Two kind 1 to ep 2 -> first DATA0, second DATA1; toggle[2] back to 0.
- poll_en=1, POLL_PERIOD=100, sw_req held continuously -> grants alternate sw/poll; poll uses PID 1001 and poll_ep; poll_done per poll.
- Never return drv_cmd_done after token -> sw_err exactly TIMEOUT_CYCLES after snd; next request accepted.
- kind 3 after toggles set -> drv_dev_rst=1 with snd, no timeout over 10000 cycles, toggles 0 after done.
- Poll blocked by long sw transaction across two periods -> one poll_overrun pulse; rst_n low mid-DAT_WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/usb_xact_sched_if.sv
// Request, poll and packet-driver signals of the USB transaction scheduler.
// The scheduler connects through the slave modport; its environment uses master.
interface usb_xact_sched_if;
    logic        sw_req;
    logic [1:0]  sw_kind;
    logic [6:0]  sw_addr;
    logic [3:0]  sw_ep;
    logic [63:0] sw_data;
    logic        sw_ack;
    logic        sw_done;
    logic        sw_err;
    logic        poll_en;
    logic [6:0]  poll_addr;
    logic [3:0]  poll_ep;
    logic        poll_done;
    logic        poll_overrun;
    logic        busy;
    logic        drv_snd;
    logic [3:0]  drv_pid;
    logic [6:0]  drv_addr;
    logic [3:0]  drv_end_pt;
    logic [63:0] drv_data;
    logic        drv_stat;
    logic        drv_dev_rst;
    logic        drv_cmd_done;

    modport slave (
        input  sw_req, sw_kind, sw_addr, sw_ep, sw_data,
        input  poll_en, poll_addr, poll_ep, drv_cmd_done,
        output sw_ack, sw_done, sw_err, poll_done, poll_overrun, busy,
        output drv_snd, drv_pid, drv_addr, drv_end_pt, drv_data, drv_stat, drv_dev_rst
    );

    modport master (
        output sw_req, sw_kind, sw_addr, sw_ep, sw_data,
        output poll_en, poll_addr, poll_ep, drv_cmd_done,
        input  sw_ack, sw_done, sw_err, poll_done, poll_overrun, busy,
        input  drv_snd, drv_pid, drv_addr, drv_end_pt, drv_data, drv_stat, drv_dev_rst
    );
endinterface

// File: rtl/usb_xact_sched.sv
// USB full-speed transaction scheduler: arbitrates software requests against a
// periodic interrupt poll and expands each into token / data / bus-reset packets.
module usb_xact_sched #(
    parameter int POLL_PERIOD    = 60000,
    parameter int GAP_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic              clk60,
    input  logic              rst_n,
    usb_xact_sched_if.slave   bus
);
    localparam int PCW = $clog2(POLL_PERIOD + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [3:0] {
        S_IDLE, S_TOK, S_TOK_WAIT, S_GAP, S_DAT, S_DAT_WAIT, S_RST, S_RST_WAIT, S_FIN
    } state_t;

    state_t      state_r;
    logic [PCW-1:0] poll_cnt_r;
    logic        poll_pending_r;
    logic        poll_overrun_r;
    logic        last_grant_poll_r;
    logic        own_poll_r;
    logic [1:0]  kind_r;
    logic [6:0]  addr_r;
    logic [3:0]  ep_r;
    logic [63:0] data_r;
    logic [15:0] toggle_r;
    logic [TCW-1:0] tmo_r;
    logic [GCW-1:0] gap_r;
    logic        sw_ack_r;
    logic        sw_done_r;
    logic        sw_err_r;
    logic        poll_done_r;
    logic        drv_snd_r;
    logic [3:0]  drv_pid_r;
    logic [6:0]  drv_addr_r;
    logic [3:0]  drv_ep_r;
    logic [63:0] drv_data_r;
    logic        drv_dev_rst_r;

    logic        grant_sw_s;
    logic        grant_poll_s;
    logic        wrap_s;

    function automatic logic [3:0] tok_pid(input logic [1:0] kind);
        case (kind)
            2'd0:    tok_pid = PID_SETUP;
            2'd1:    tok_pid = PID_OUT;
            default: tok_pid = PID_IN;
        endcase
    endfunction

    function automatic logic [3:0] data_pid(input logic [1:0] kind, input logic tog);
        if (kind == 2'd0)
            data_pid = PID_DATA0;
        else if (tog)
            data_pid = PID_DATA1;
        else
            data_pid = PID_DATA0;
    endfunction

    assign wrap_s = bus.poll_en && (poll_cnt_r == PCW'(POLL_PERIOD - 1));

    // Round-robin arbitration between software and poll, evaluated only in IDLE
    always_comb begin
        grant_sw_s   = 1'b0;
        grant_poll_s = 1'b0;
        if (state_r == S_IDLE) begin
            if (bus.sw_req && poll_pending_r) begin
                if (last_grant_poll_r)
                    grant_sw_s = 1'b1;
                else
                    grant_poll_s = 1'b1;
            end else if (bus.sw_req) begin
                grant_sw_s = 1'b1;
            end else if (poll_pending_r) begin
                grant_poll_s = 1'b1;
            end else begin
                grant_sw_s   = 1'b0;
                grant_poll_s = 1'b0;
            end
        end else begin
            grant_sw_s   = 1'b0;
            grant_poll_s = 1'b0;
        end
    end

    // Poll period timer, pending flag and overrun detection
    always_ff @(posedge clk60) begin
        if (!rst_n) begin
            poll_cnt_r     <= '0;
            poll_pending_r <= 1'b0;
            poll_overrun_r <= 1'b0;
        end else begin
            poll_overrun_r <= 1'b0;
            if (!bus.poll_en)
                poll_cnt_r <= '0;
            else if (wrap_s)
                poll_cnt_r <= '0;
            else
                poll_cnt_r <= poll_cnt_r + PCW'(1);
            // A wrap with an unserved poll still outstanding is an overrun;
            // a grant landing on the wrap cycle consumes the old poll instead.
            if (wrap_s) begin
                poll_pending_r <= 1'b1;
                if (poll_pending_r && !grant_poll_s)
                    poll_overrun_r <= 1'b1;
            end else if (grant_poll_s) begin
                poll_pending_r <= 1'b0;
            end
        end
    end

    // Transaction FSM: request latch, packet sequencing, toggles and timeouts
    always_ff @(posedge clk60) begin
        if (!rst_n) begin
            state_r           <= S_IDLE;
            last_grant_poll_r <= 1'b1;
            own_poll_r        <= 1'b0;
            kind_r            <= 2'd0;
            addr_r            <= 7'd0;
            ep_r              <= 4'd0;
            data_r            <= 64'd0;
            toggle_r          <= 16'd0;
            tmo_r             <= '0;
            gap_r             <= '0;
            sw_ack_r          <= 1'b0;
            sw_done_r         <= 1'b0;
            sw_err_r          <= 1'b0;
            poll_done_r       <= 1'b0;
            drv_snd_r         <= 1'b0;
            drv_pid_r         <= 4'd0;
            drv_addr_r        <= 7'd0;
            drv_ep_r          <= 4'd0;
            drv_data_r        <= 64'd0;
            drv_dev_rst_r     <= 1'b0;
        end else begin
            sw_ack_r    <= 1'b0;
            sw_done_r   <= 1'b0;
            sw_err_r    <= 1'b0;
            poll_done_r <= 1'b0;
            drv_snd_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (grant_sw_s) begin
                        kind_r            <= bus.sw_kind;
                        addr_r            <= bus.sw_addr;
                        ep_r              <= bus.sw_ep;
                        data_r            <= bus.sw_data;
                        own_poll_r        <= 1'b0;
                        last_grant_poll_r <= 1'b0;
                        sw_ack_r          <= 1'b1;
                        state_r           <= S_TOK;
                    end else if (grant_poll_s) begin
                        kind_r            <= 2'd2;
                        addr_r            <= bus.poll_addr;
                        ep_r              <= bus.poll_ep;
                        data_r            <= 64'd0;
                        own_poll_r        <= 1'b1;
                        last_grant_poll_r <= 1'b1;
                        state_r           <= S_TOK;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_TOK: begin
                    if (kind_r == 2'd3) begin
                        state_r <= S_RST;
                    end else begin
                        drv_snd_r     <= 1'b1;
                        drv_pid_r     <= tok_pid(kind_r);
                        drv_addr_r    <= addr_r;
                        drv_ep_r      <= ep_r;
                        drv_data_r    <= 64'd0;
                        drv_dev_rst_r <= 1'b0;
                        tmo_r         <= '0;
                        state_r       <= S_TOK_WAIT;
                    end
                end
                S_TOK_WAIT: begin
                    if (bus.drv_cmd_done) begin
                        gap_r <= '0;
                        if (kind_r == 2'd2) begin
                            sw_done_r   <= !own_poll_r;
                            poll_done_r <= own_poll_r;
                            state_r     <= S_FIN;
                        end else begin
                            state_r <= S_GAP;
                        end
                    end else if (tmo_r == TCW'(TIMEOUT_CYCLES - 1)) begin
                        sw_err_r <= !own_poll_r;
                        state_r  <= S_IDLE;
                    end else begin
                        tmo_r <= tmo_r + TCW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_r == GCW'(GAP_CYCLES - 1))
                        state_r <= S_DAT;
                    else
                        gap_r <= gap_r + GCW'(1);
                end
                S_DAT: begin
                    drv_snd_r     <= 1'b1;
                    drv_pid_r     <= data_pid(kind_r, toggle_r[ep_r]);
                    drv_addr_r    <= addr_r;
                    drv_ep_r      <= ep_r;
                    drv_data_r    <= data_r;
                    drv_dev_rst_r <= 1'b0;
                    tmo_r         <= '0;
                    state_r       <= S_DAT_WAIT;
                end
                S_DAT_WAIT: begin
                    if (bus.drv_cmd_done) begin
                        // SETUP always resynchronises the endpoint to DATA1 next
                        if (kind_r == 2'd0)
                            toggle_r[ep_r] <= 1'b1;
                        else
                            toggle_r[ep_r] <= ~toggle_r[ep_r];
                        sw_done_r   <= !own_poll_r;
                        poll_done_r <= own_poll_r;
                        gap_r       <= '0;
                        state_r     <= S_FIN;
                    end else if (tmo_r == TCW'(TIMEOUT_CYCLES - 1)) begin
                        sw_err_r <= !own_poll_r;
                        state_r  <= S_IDLE;
                    end else begin
                        tmo_r <= tmo_r + TCW'(1);
                    end
                end
                S_RST: begin
                    drv_snd_r     <= 1'b1;
                    drv_pid_r     <= 4'd0;
                    drv_addr_r    <= addr_r;
                    drv_ep_r      <= ep_r;
                    drv_data_r    <= 64'd0;
                    drv_dev_rst_r <= 1'b1;
                    state_r       <= S_RST_WAIT;
                end
                S_RST_WAIT: begin
                    // Bus reset can legitimately take milliseconds, so no timeout here
                    if (bus.drv_cmd_done) begin
                        toggle_r    <= 16'd0;
                        sw_done_r   <= !own_poll_r;
                        poll_done_r <= own_poll_r;
                        gap_r       <= '0;
                        state_r     <= S_FIN;
                    end else begin
                        state_r <= S_RST_WAIT;
                    end
                end
                S_FIN: begin
                    if (gap_r == GCW'(GAP_CYCLES - 1))
                        state_r <= S_IDLE;
                    else
                        gap_r <= gap_r + GCW'(1);
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sw_ack       = sw_ack_r;
    assign bus.sw_done      = sw_done_r;
    assign bus.sw_err       = sw_err_r;
    assign bus.poll_done    = poll_done_r;
    assign bus.poll_overrun = poll_overrun_r;
    assign bus.busy         = (state_r != S_IDLE);
    assign bus.drv_snd      = drv_snd_r;
    assign bus.drv_pid      = drv_pid_r;
    assign bus.drv_addr     = drv_addr_r;
    assign bus.drv_end_pt   = drv_ep_r;
    assign bus.drv_data     = drv_data_r;
    assign bus.drv_stat     = 1'b0;
    assign bus.drv_dev_rst  = drv_dev_rst_r;
endmodule

// File: tb/tb_usb_xact_sched.sv
// Self-checking bench for usb_xact_sched: directed vector table, random requests
// against a transaction-level toggle model, and poll/timeout/reset sequences.
module tb_usb_xact_sched;
    localparam int POLL_P = 100;
    localparam int GAP    = 20;
    localparam int TMO    = 4095;

    localparam logic [3:0] SETUP = 4'b1101;
    localparam logic [3:0] OUTP  = 4'b0001;
    localparam logic [3:0] INP   = 4'b1001;
    localparam logic [3:0] D0    = 4'b0011;
    localparam logic [3:0] D1    = 4'b1011;

    logic clk60 = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk60 = ~clk60;

    usb_xact_sched_if ifc();

    usb_xact_sched #(
        .POLL_PERIOD(POLL_P), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk60(clk60),
        .rst_n(rst_n),
        .bus(ifc)
    );

    typedef struct {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  ep;
        logic [63:0] data;
        logic        rst;
        int          t;
    } pkt_t;

    typedef struct {
        logic [1:0]  kind;
        logic [6:0]  addr;
        logic [3:0]  ep;
        logic [63:0] data;
        logic [3:0]  tok;
        logic [3:0]  dat;
    } vec_t;

    pkt_t snd_q[$];
    int n_ack = 0, n_sw_done = 0, n_poll_done = 0, n_ovr = 0;
    int n_pass = 0, n_chk = 0;
    int resp_delay = 30;
    bit resp_on = 1'b1;
    int resp_cnt = 0;
    logic [15:0] ref_tog = 16'd0;

    always @(posedge clk60) cyc <= cyc + 1;

    // Record every packet sent to the driver and count the handshake pulses
    always @(negedge clk60) begin
        if (ifc.drv_snd)
            snd_q.push_back('{ifc.drv_pid, ifc.drv_addr, ifc.drv_end_pt, ifc.drv_data, ifc.drv_dev_rst, cyc});
        if (ifc.sw_ack)       n_ack       <= n_ack + 1;
        if (ifc.sw_done)      n_sw_done   <= n_sw_done + 1;
        if (ifc.poll_done)    n_poll_done <= n_poll_done + 1;
        if (ifc.poll_overrun) n_ovr       <= n_ovr + 1;
    end

    // Driver model: completes each packet resp_delay cycles after its strobe
    initial begin
        ifc.drv_cmd_done = 1'b0;
        forever begin
            @(negedge clk60);
            ifc.drv_cmd_done = 1'b0;
            if (!rst_n) begin
                resp_cnt = 0;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt = resp_cnt - 1;
                    if (resp_cnt == 0) ifc.drv_cmd_done = 1'b1;
                end
                if (ifc.drv_snd && resp_on) resp_cnt = resp_delay;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [3:0] ref_dat_pid(input logic [1:0] kind, input logic [3:0] ep);
        if (kind == 2'd0) return D0;
        return ref_tog[ep] ? D1 : D0;
    endfunction

    function automatic logic [3:0] ref_tok_pid(input logic [1:0] kind);
        if (kind == 2'd0) return SETUP;
        if (kind == 2'd1) return OUTP;
        return INP;
    endfunction

    task automatic ref_update(input logic [1:0] kind, input logic [3:0] ep);
        if (kind == 2'd0) ref_tog[ep] = 1'b1;
        else if (kind == 2'd1) ref_tog[ep] = ~ref_tog[ep];
        else if (kind == 2'd3) ref_tog = 16'd0;
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, " ctl"}, {ifc.sw_ack, ifc.sw_done, ifc.sw_err, ifc.poll_done, ifc.poll_overrun,
                             ifc.busy, ifc.drv_snd, ifc.drv_pid, ifc.drv_addr, ifc.drv_end_pt,
                             ifc.drv_stat, ifc.drv_dev_rst}, 64'd0);
        chk({name, " data"}, ifc.drv_data, 64'd0);
    endtask

    task automatic wait_ack(input string tag);
        int w = 0;
        while (!ifc.sw_ack && w < 200) begin @(negedge clk60); w++; end
        ifc.sw_req = 1'b0;
        chk({tag, " ack"}, ifc.sw_ack, 1'b1);
    endtask

    // One software transaction, checked against the expected packet sequence
    task automatic run_xact(input logic [1:0] kind, input logic [6:0] addr, input logic [3:0] ep,
                            input logic [63:0] data, input logic [3:0] exp_tok,
                            input logic [3:0] exp_dat, input bit exp_tmo, input string tag);
        int w, nd, t_end, npk;
        bit got_err;
        snd_q.delete();
        @(negedge clk60);
        ifc.sw_kind = kind; ifc.sw_addr = addr; ifc.sw_ep = ep; ifc.sw_data = data;
        ifc.sw_req = 1'b1;
        wait_ack(tag);
        w = 0;
        while (!(ifc.sw_done || ifc.sw_err) && w < 12000) begin @(negedge clk60); w++; end
        t_end = cyc;
        got_err = ifc.sw_err;
        chk({tag, " err"}, got_err, exp_tmo);
        chk({tag, " finished"}, ifc.sw_done || ifc.sw_err, 1'b1);
        nd = 0; w = 0;
        while (ifc.busy && w < 100) begin
            @(negedge clk60); w++;
            if (ifc.sw_done || ifc.sw_err) nd++;
        end
        chk({tag, " extra pulses"}, nd, 0);
        npk = (exp_tmo || kind >= 2'd2) ? 1 : 2;
        chk({tag, " packets"}, snd_q.size(), npk);
        if (snd_q.size() >= 1) begin
            if (kind != 2'd3) chk({tag, " tok pid"}, snd_q[0].pid, exp_tok);
            chk({tag, " tok addr"}, snd_q[0].addr, addr);
            chk({tag, " tok ep"}, snd_q[0].ep, ep);
            chk({tag, " dev_rst"}, snd_q[0].rst, kind == 2'd3);
            if (exp_tmo) chk({tag, " timeout latency"}, t_end - snd_q[0].t, TMO);
        end
        if (snd_q.size() >= 2 && kind < 2'd2) begin
            chk({tag, " dat pid"}, snd_q[1].pid, exp_dat);
            chk({tag, " dat data"}, snd_q[1].data, data);
            chk({tag, " dat gap"}, (snd_q[1].t - (snd_q[0].t + resp_delay) - 1) >= GAP, 1'b1);
        end
        if (!exp_tmo) ref_update(kind, ep);
    endtask

    vec_t vt[9];

    initial begin
        int a0, d0, p0, o0, np, consec, badpid, w;
        bit prev_poll;
        logic [1:0]  rk;
        logic [3:0]  re;
        logic [63:0] rd;

        vt[0] = '{2'd0, 7'h05, 4'd0, 64'h1122334455667788, SETUP, D0};
        vt[1] = '{2'd1, 7'h05, 4'd2, 64'hA5A5_0000_FFFF_1234, OUTP, D0};
        vt[2] = '{2'd1, 7'h05, 4'd2, 64'h0BAD_CAFE_DEAD_BEEF, OUTP, D1};
        vt[3] = '{2'd2, 7'h09, 4'd3, 64'd0, INP, D0};
        vt[4] = '{2'd1, 7'h05, 4'd0, 64'h0123_4567_89AB_CDEF, OUTP, D1};
        vt[5] = '{2'd1, 7'h33, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, OUTP, D0};
        vt[6] = '{2'd3, 7'h00, 4'd0, 64'd0, 4'd0, D0};
        vt[7] = '{2'd1, 7'h33, 4'd5, 64'h5555_AAAA_5555_AAAA, OUTP, D0};
        vt[8] = '{2'd1, 7'h05, 4'd2, 64'h0000_0000_0000_0001, OUTP, D0};

        ifc.sw_req = 1'b0; ifc.sw_kind = 2'd0; ifc.sw_addr = 7'd0; ifc.sw_ep = 4'd0;
        ifc.sw_data = 64'd0; ifc.poll_en = 1'b0; ifc.poll_addr = 7'h42; ifc.poll_ep = 4'd7;
        rst_n = 1'b0;
        repeat (3) @(negedge clk60);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Directed vectors; the bus-reset row uses a completion slower than the timeout
        for (int i = 0; i < 9; i++) begin
            resp_delay = (vt[i].kind == 2'd3) ? 5000 : 30;
            run_xact(vt[i].kind, vt[i].addr, vt[i].ep, vt[i].data, vt[i].tok, vt[i].dat, 1'b0,
                     $sformatf("vec%0d", i));
        end

        resp_delay = 30;
        resp_on = 1'b0;
        run_xact(2'd1, 7'h0A, 4'd3, 64'h77, OUTP, D0, 1'b1, "timeout");
        resp_on = 1'b1;
        run_xact(2'd2, 7'h0A, 4'd3, 64'd0, INP, D0, 1'b0, "after_timeout");

        for (int i = 0; i < 20; i++) begin
            rk = 2'($urandom_range(0, 3));
            re = 4'($urandom_range(0, 15));
            rd = {32'($urandom), 32'($urandom)};
            resp_delay = $urandom_range(1, 40);
            run_xact(rk, 7'($urandom_range(0, 127)), re, rd, ref_tok_pid(rk), ref_dat_pid(rk, re),
                     1'b0, $sformatf("rnd%0d", i));
        end

        // Software request held continuously while polling every POLL_P cycles
        resp_delay = 5;
        snd_q.delete();
        a0 = n_ack; d0 = n_sw_done; p0 = n_poll_done; o0 = n_ovr;
        @(negedge clk60);
        ifc.sw_kind = 2'd2; ifc.sw_addr = 7'h11; ifc.sw_ep = 4'd1; ifc.sw_req = 1'b1;
        ifc.poll_en = 1'b1;
        repeat (1000) @(negedge clk60);
        ifc.poll_en = 1'b0;
        ifc.sw_req = 1'b0;
        repeat (200) @(negedge clk60);
        chk("alt poll_done", n_poll_done - p0, 10);
        chk("alt overrun", n_ovr - o0, 0);
        chk("alt sw done vs ack", n_sw_done - d0, n_ack - a0);
        chk("alt sw granted", (n_ack - a0) >= 10, 1'b1);
        np = 0; consec = 0; badpid = 0; prev_poll = 1'b0;
        foreach (snd_q[i]) begin
            if (snd_q[i].pid != INP) badpid++;
            if (snd_q[i].addr == 7'h42 && snd_q[i].ep == 4'd7) begin
                np++;
                if (prev_poll) consec++;
                prev_poll = 1'b1;
            end else begin
                prev_poll = 1'b0;
            end
        end
        chk("alt poll tokens", np, 10);
        chk("alt back-to-back polls", consec, 0);
        chk("alt non-IN pids", badpid, 0);

        // Long software transaction spanning two poll periods
        resp_delay = 110;
        a0 = n_ack; d0 = n_sw_done; p0 = n_poll_done; o0 = n_ovr;
        @(negedge clk60);
        ifc.sw_kind = 2'd1; ifc.sw_addr = 7'h21; ifc.sw_ep = 4'd9; ifc.sw_data = 64'h99;
        ifc.sw_req = 1'b1; ifc.poll_en = 1'b1;
        wait_ack("ovr");
        w = 0;
        while (!ifc.sw_done && w < 1000) begin @(negedge clk60); w++; end
        ifc.poll_en = 1'b0;
        w = 0;
        while (!ifc.poll_done && w < 1000) begin @(negedge clk60); w++; end
        repeat (30) @(negedge clk60);
        ref_update(2'd1, 4'd9);
        chk("ovr pulses", n_ovr - o0, 1);
        chk("ovr poll_done", n_poll_done - p0, 1);
        chk("ovr sw_done", n_sw_done - d0, 1);

        // Reset while the DATA packet is outstanding
        resp_delay = 30;
        run_xact(2'd0, 7'h05, 4'd0, 64'h1, SETUP, D0, 1'b0, "pre_reset");
        snd_q.delete();
        d0 = n_sw_done;
        @(negedge clk60);
        ifc.sw_kind = 2'd1; ifc.sw_addr = 7'h05; ifc.sw_ep = 4'd0; ifc.sw_data = 64'h2;
        ifc.sw_req = 1'b1;
        wait_ack("midrst");
        w = 0;
        while (snd_q.size() < 2 && w < 500) begin @(negedge clk60); w++; end
        chk("midrst reached data", snd_q.size(), 2);
        repeat (3) @(negedge clk60);
        rst_n = 1'b0;
        @(negedge clk60);
        check_idle_outputs("midrst");
        repeat (2) @(negedge clk60);
        rst_n = 1'b1;
        ref_tog = 16'd0;
        repeat (40) @(negedge clk60);
        chk("midrst no done", n_sw_done - d0, 0);
        run_xact(2'd1, 7'h05, 4'd0, 64'h3, OUTP, ref_dat_pid(2'd1, 4'd0), 1'b0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
